// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch-group PC generator: redirect sources, FSM states, BTB field widths.
package pc_gen_pkg;

    localparam int PC_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_CTRL = 2'd1,
        SRC_BR   = 2'd2,
        SRC_JP   = 2'd3
    } redir_src_e;

    typedef enum logic {
        BUBBLE = 1'b0,
        RUN    = 1'b1
    } state_e;

    localparam int BTB_VALID_W = 1;

    function automatic int btb_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int btb_tag_w(input int pc_width, input int depth);
        return pc_width - 2 - btb_idx_w(depth);
    endfunction

endpackage

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer: combinational lookup across one fetch group, registered update.
module pc_gen_btb
    import pc_gen_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int FETCH_WIDTH = 2,
    parameter int BTB_DEPTH   = 8,
    parameter int SLOT_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PC_WIDTH-1:0] group_base,
    input  logic [SLOT_W-1:0]   start_slot,
    output logic                hit,
    output logic [SLOT_W-1:0]   hit_slot,
    output logic [PC_WIDTH-1:0] hit_target,
    input  logic                upd_en,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic [PC_WIDTH-1:0] upd_target
);

    localparam int IDX_W = btb_idx_w(BTB_DEPTH);
    localparam int TAG_W = btb_tag_w(PC_WIDTH, BTB_DEPTH);

    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
    logic [PC_WIDTH-3:0]  target_q [BTB_DEPTH];

    logic [IDX_W-1:0]    upd_idx;
    logic [TAG_W-1:0]    upd_tag;
    logic [PC_WIDTH-3:0] slot_word;
    logic                unused_bits;

    assign upd_idx     = upd_pc[2 +: IDX_W];
    assign upd_tag     = upd_pc[PC_WIDTH-1 -: TAG_W];
    assign unused_bits = ^{upd_pc[1:0], upd_target[1:0], group_base[1:0]};

    // Scan from the top slot down so the lowest-index hit is the one left standing.
    always_comb begin
        hit        = 1'b0;
        hit_slot   = '0;
        hit_target = '0;
        slot_word  = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            slot_word = group_base[PC_WIDTH-1:2] + (PC_WIDTH-2)'(i);
            if ((SLOT_W'(i) >= start_slot) && valid_q[slot_word[IDX_W-1:0]] &&
                (tag_q[slot_word[IDX_W-1:0]] == slot_word[PC_WIDTH-3 -: TAG_W])) begin
                hit        = 1'b1;
                hit_slot   = SLOT_W'(i);
                hit_target = {target_q[slot_word[IDX_W-1:0]], 2'b00};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (en && upd_en) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en && upd_en) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target[PC_WIDTH-1:2];
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-group PC generator with epoch-tagged redirects.
// Define PCGEN_BTB_EN to add the pc_gen_btb predictor; otherwise fetch is purely sequential.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                  PC_WIDTH    = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VEC   = '0,
    parameter int                  FETCH_WIDTH = 2,
    parameter int                  EPOCH_WIDTH = 2,
    parameter int                  BTB_DEPTH   = 8
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_en,
    input  logic                   fetch_ready,
    output logic                   fetch_valid,
    output logic [PC_WIDTH-1:0]    fetch_pc,
    output logic [FETCH_WIDTH-1:0] fetch_mask,
    output logic [EPOCH_WIDTH-1:0] fetch_epoch,
    output logic                   pred_taken,
    input  logic                   trap_happened,
    input  logic                   mret_en,
    input  logic [PC_WIDTH-1:0]    ctrl_pc,
    input  logic                   br_taken,
    input  logic [PC_WIDTH-1:0]    br_addr,
    input  logic [PC_WIDTH-1:0]    br_pc,
    input  logic                   jp_taken,
    input  logic [PC_WIDTH-1:0]    jp_addr,
    input  logic [PC_WIDTH-1:0]    jp_pc
);

    localparam int GB     = 4 * FETCH_WIDTH;
    localparam int GB_LOG = $clog2(GB);
    localparam int SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    state_e                 state;
    logic [PC_WIDTH-1:0]    pc;
    logic [EPOCH_WIDTH-1:0] epoch;

    logic [PC_WIDTH-1:0]    group_base;
    logic [PC_WIDTH-1:0]    seq_next;
    logic [PC_WIDTH-1:0]    next_pc;
    logic [SLOT_W-1:0]      slot;
    logic [FETCH_WIDTH-1:0] mask_raw;
    logic                   pred_hit;
    logic [SLOT_W-1:0]      pred_slot;
    logic [PC_WIDTH-1:0]    pred_target;
    redir_src_e             redir_src;
    logic [PC_WIDTH-1:0]    redir_target;

    assign group_base = {pc[PC_WIDTH-1:GB_LOG], {GB_LOG{1'b0}}};
    assign seq_next   = group_base + PC_WIDTH'(GB);

    generate
        if (FETCH_WIDTH > 1) begin : g_slot
            assign slot = pc[GB_LOG-1:2];
        end else begin : g_slot_single
            assign slot = '0;
        end
    endgenerate

`ifdef PCGEN_BTB_EN
    logic                btb_upd_en;
    logic [PC_WIDTH-1:0] btb_upd_pc;
    logic [PC_WIDTH-1:0] btb_upd_tgt;

    // Branch training wins over jump; trap/mret never train, even when they own the redirect.
    assign btb_upd_en  = br_taken || jp_taken;
    assign btb_upd_pc  = br_taken ? br_pc : jp_pc;
    assign btb_upd_tgt = br_taken ? br_addr : jp_addr;

    pc_gen_btb #(
        .PC_WIDTH    (PC_WIDTH),
        .FETCH_WIDTH (FETCH_WIDTH),
        .BTB_DEPTH   (BTB_DEPTH),
        .SLOT_W      (SLOT_W)
    ) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (cpu_en),
        .group_base (group_base),
        .start_slot (slot),
        .hit        (pred_hit),
        .hit_slot   (pred_slot),
        .hit_target (pred_target),
        .upd_en     (btb_upd_en),
        .upd_pc     (btb_upd_pc),
        .upd_target (btb_upd_tgt)
    );
`else
    logic unused_btb;

    assign pred_hit    = 1'b0;
    assign pred_slot   = '0;
    assign pred_target = '0;
    assign unused_btb  = ^{br_pc, jp_pc, BTB_DEPTH[0]};
`endif

    always_comb begin
        mask_raw = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            mask_raw[i] = (SLOT_W'(i) >= slot) && (!pred_hit || (SLOT_W'(i) <= pred_slot));
        end
    end

    assign next_pc = pred_hit ? pred_target : seq_next;

    always_comb begin
        redir_src    = SRC_NONE;
        redir_target = '0;
        if (trap_happened || mret_en) begin
            redir_src    = SRC_CTRL;
            redir_target = ctrl_pc;
        end else if (br_taken) begin
            redir_src    = SRC_BR;
            redir_target = br_addr;
        end else if (jp_taken) begin
            redir_src    = SRC_JP;
            redir_target = jp_addr;
        end
    end

    assign fetch_valid = (state == RUN) && cpu_en;
    assign fetch_pc    = pc;
    assign fetch_mask  = fetch_valid ? mask_raw : '0;
    assign fetch_epoch = epoch;
    assign pred_taken  = fetch_valid && pred_hit;

    // A redirect always lands, even against a stall, and costs one bubble cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_VEC;
            state <= BUBBLE;
            epoch <= '0;
        end else if (cpu_en) begin
            if (redir_src != SRC_NONE) begin
                pc    <= {redir_target[PC_WIDTH-1:2], 2'b00};
                epoch <= epoch + EPOCH_WIDTH'(1);
                state <= BUBBLE;
            end else if (state == BUBBLE) begin
                state <= RUN;
            end else if (fetch_ready) begin
                pc <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen (FETCH_WIDTH=2, RESET_VEC=0x100); BTB expectations follow PCGEN_BTB_EN.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_en;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_mask;
    logic [1:0]  fetch_epoch;
    logic        pred_taken;
    logic        trap_happened;
    logic        mret_en;
    logic [31:0] ctrl_pc;
    logic        br_taken;
    logic [31:0] br_addr;
    logic [31:0] br_pc;
    logic        jp_taken;
    logic [31:0] jp_addr;
    logic [31:0] jp_pc;

    int vectors     = 0;
    int miscompares = 0;

    logic        e_v;
    logic [31:0] e_pc;
    logic [1:0]  e_m;
    logic [1:0]  e_e;
    logic        e_p;
    string       nm;

    always #5 clk = ~clk;

    pc_gen #(
        .PC_WIDTH    (32),
        .RESET_VEC   (32'h0000_0100),
        .FETCH_WIDTH (2),
        .EPOCH_WIDTH (2),
        .BTB_DEPTH   (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_en        (cpu_en),
        .fetch_ready   (fetch_ready),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_mask    (fetch_mask),
        .fetch_epoch   (fetch_epoch),
        .pred_taken    (pred_taken),
        .trap_happened (trap_happened),
        .mret_en       (mret_en),
        .ctrl_pc       (ctrl_pc),
        .br_taken      (br_taken),
        .br_addr       (br_addr),
        .br_pc         (br_pc),
        .jp_taken      (jp_taken),
        .jp_addr       (jp_addr),
        .jp_pc         (jp_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        trap_happened = 1'b0;
        mret_en       = 1'b0;
        ctrl_pc       = '0;
        br_taken      = 1'b0;
        br_addr       = '0;
        br_pc         = '0;
        jp_taken      = 1'b0;
        jp_addr       = '0;
        jp_pc         = '0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'h100, 32'h108, 32'h110};
        rst_n = 1'b0; cpu_en = 1'b1; fetch_ready = 1'b1;
        clear_redirects();
        tick(); tick();
        nm = "reset_values"; {e_v, e_pc, e_m, e_e, e_p} = {1'b0, 32'h100, 2'b00, 2'd0, 1'b0};
        vectors++;
        if ({fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken} !== {e_v, e_pc, e_m, e_e, e_p}) begin
            miscompares++;
            $display("[TB] FAIL %s: got v=%b pc=%h m=%b e=%0d p=%b, expected v=%b pc=%h m=%b e=%0d p=%b",
                     nm, fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken, e_v, e_pc, e_m, e_e, e_p);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (fetch_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL release_no_valid: got v=%b, expected v=0", fetch_valid);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            nm = "reset_sequence"; {e_v, e_pc, e_m, e_e, e_p} = {1'b1, exp_pc[k], 2'b11, 2'd0, 1'b0};
            vectors++;
            if ({fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken} !== {e_v, e_pc, e_m, e_e, e_p}) begin
                miscompares++;
                $display("[TB] FAIL %s: got v=%b pc=%h m=%b e=%0d p=%b, expected v=%b pc=%h m=%b e=%0d p=%b",
                         nm, fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken, e_v, e_pc, e_m, e_e, e_p);
            end
            if (k < 2) tick();
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp_pc [3];
        logic [1:0]  exp_m  [3];
        logic        exp_v  [3];
        exp_pc = '{32'h204, 32'h204, 32'h208};
        exp_m  = '{2'b00, 2'b10, 2'b11};
        exp_v  = '{1'b0, 1'b1, 1'b1};
        br_taken = 1'b1; br_addr = 32'h204; br_pc = 32'h50;
        tick();
        clear_redirects();
        for (int k = 0; k < 3; k++) begin
            nm = "branch_redirect"; {e_v, e_pc, e_m, e_e, e_p} = {exp_v[k], exp_pc[k], exp_m[k], 2'd1, 1'b0};
            vectors++;
            if ({fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken} !== {e_v, e_pc, e_m, e_e, e_p}) begin
                miscompares++;
                $display("[TB] FAIL %s[%0d]: got v=%b pc=%h m=%b e=%0d p=%b, expected v=%b pc=%h m=%b e=%0d p=%b",
                         nm, k, fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken, e_v, e_pc, e_m, e_e, e_p);
            end
            if (k < 2) tick();
        end
    endtask

    task automatic test_priority();
        trap_happened = 1'b1; ctrl_pc = 32'h82;
        br_taken = 1'b1; br_addr = 32'h500; br_pc = 32'h60;
        jp_taken = 1'b1; jp_addr = 32'h600; jp_pc = 32'h70;
        tick();
        clear_redirects();
        for (int k = 0; k < 2; k++) begin
            nm = "priority_trap";
            {e_v, e_pc, e_m, e_e, e_p} = {(k == 1), 32'h80, (k == 1) ? 2'b11 : 2'b00, 2'd2, 1'b0};
            vectors++;
            if ({fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken} !== {e_v, e_pc, e_m, e_e, e_p}) begin
                miscompares++;
                $display("[TB] FAIL %s[%0d]: got v=%b pc=%h m=%b e=%0d p=%b, expected v=%b pc=%h m=%b e=%0d p=%b",
                         nm, k, fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken, e_v, e_pc, e_m, e_e, e_p);
            end
            if (k == 0) tick();
        end
    endtask

    task automatic test_stall();
        fetch_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            nm = "stall_hold"; {e_v, e_pc, e_m, e_e, e_p} = {1'b1, 32'h80, 2'b11, 2'd2, 1'b0};
            vectors++;
            if ({fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken} !== {e_v, e_pc, e_m, e_e, e_p}) begin
                miscompares++;
                $display("[TB] FAIL %s[%0d]: got v=%b pc=%h m=%b e=%0d p=%b, expected v=%b pc=%h m=%b e=%0d p=%b",
                         nm, k, fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken, e_v, e_pc, e_m, e_e, e_p);
            end
        end
        jp_taken = 1'b1; jp_addr = 32'h300; jp_pc = 32'h90;
        tick();
        clear_redirects();
        for (int k = 0; k < 2; k++) begin
            nm = "stall_redirect";
            {e_v, e_pc, e_m, e_e, e_p} = {(k == 1), 32'h300, (k == 1) ? 2'b11 : 2'b00, 2'd3, 1'b0};
            vectors++;
            if ({fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken} !== {e_v, e_pc, e_m, e_e, e_p}) begin
                miscompares++;
                $display("[TB] FAIL %s[%0d]: got v=%b pc=%h m=%b e=%0d p=%b, expected v=%b pc=%h m=%b e=%0d p=%b",
                         nm, k, fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken, e_v, e_pc, e_m, e_e, e_p);
            end
            if (k == 0) begin
                fetch_ready = 1'b1;
                tick();
            end
        end
    endtask

    task automatic test_reset_async();
        fetch_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        nm = "async_reset"; {e_v, e_pc, e_m, e_e, e_p} = {1'b0, 32'h100, 2'b00, 2'd0, 1'b0};
        vectors++;
        if ({fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken} !== {e_v, e_pc, e_m, e_e, e_p}) begin
            miscompares++;
            $display("[TB] FAIL %s: got v=%b pc=%h m=%b e=%0d p=%b, expected v=%b pc=%h m=%b e=%0d p=%b",
                     nm, fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken, e_v, e_pc, e_m, e_e, e_p);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fetch_ready = 1'b1;
        tick();
        nm = "reset_rerun"; {e_v, e_pc, e_m, e_e, e_p} = {1'b1, 32'h100, 2'b11, 2'd0, 1'b0};
        vectors++;
        if ({fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken} !== {e_v, e_pc, e_m, e_e, e_p}) begin
            miscompares++;
            $display("[TB] FAIL %s: got v=%b pc=%h m=%b e=%0d p=%b, expected v=%b pc=%h m=%b e=%0d p=%b",
                     nm, fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken, e_v, e_pc, e_m, e_e, e_p);
        end
    endtask

    task automatic test_epoch_wrap();
        logic [1:0] exp_e [4];
        exp_e = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 4; k++) begin
            trap_happened = 1'b1;
            ctrl_pc = 32'h1000 + 32'(k * 16);
            tick();
            nm = "epoch_wrap"; {e_v, e_pc, e_m, e_e, e_p} = {1'b0, ctrl_pc, 2'b00, exp_e[k], 1'b0};
            vectors++;
            if ({fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken} !== {e_v, e_pc, e_m, e_e, e_p}) begin
                miscompares++;
                $display("[TB] FAIL %s[%0d]: got v=%b pc=%h m=%b e=%0d p=%b, expected v=%b pc=%h m=%b e=%0d p=%b",
                         nm, k, fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken, e_v, e_pc, e_m, e_e, e_p);
            end
        end
        clear_redirects();
        tick();
        nm = "wrap_target"; {e_v, e_pc, e_m, e_e, e_p} = {1'b1, 32'h1030, 2'b11, 2'd0, 1'b0};
        vectors++;
        if ({fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken} !== {e_v, e_pc, e_m, e_e, e_p}) begin
            miscompares++;
            $display("[TB] FAIL %s: got v=%b pc=%h m=%b e=%0d p=%b, expected v=%b pc=%h m=%b e=%0d p=%b",
                     nm, fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken, e_v, e_pc, e_m, e_e, e_p);
        end
    endtask

    task automatic test_cpu_en();
        logic [31:0] exp_pc [4];
        logic        exp_v  [4];
        exp_pc = '{32'h1030, 32'h1030, 32'h1030, 32'h1038};
        exp_v  = '{1'b0, 1'b0, 1'b1, 1'b1};
        cpu_en = 1'b0;
        br_taken = 1'b1; br_addr = 32'h700; br_pc = 32'h44;
        #1;
        for (int k = 0; k < 4; k++) begin
            nm = "cpu_en_freeze";
            {e_v, e_pc, e_m, e_e, e_p} = {exp_v[k], exp_pc[k], exp_v[k] ? 2'b11 : 2'b00, 2'd0, 1'b0};
            vectors++;
            if ({fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken} !== {e_v, e_pc, e_m, e_e, e_p}) begin
                miscompares++;
                $display("[TB] FAIL %s[%0d]: got v=%b pc=%h m=%b e=%0d p=%b, expected v=%b pc=%h m=%b e=%0d p=%b",
                         nm, k, fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken, e_v, e_pc, e_m, e_e, e_p);
            end
            if (k == 0) begin
                tick(); tick();
            end else if (k == 1) begin
                clear_redirects();
                cpu_en = 1'b1;
                #1;
            end else if (k == 2) begin
                tick();
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic [31:0] exp_pc [3];
        logic [1:0]  exp_m  [3];
        exp_pc = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        exp_m  = '{2'b00, 2'b10, 2'b11};
        trap_happened = 1'b1; ctrl_pc = 32'hFFFF_FFFF;
        tick();
        clear_redirects();
        for (int k = 0; k < 3; k++) begin
            nm = "addr_wrap"; {e_v, e_pc, e_m, e_e, e_p} = {(k != 0), exp_pc[k], exp_m[k], 2'd1, 1'b0};
            vectors++;
            if ({fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken} !== {e_v, e_pc, e_m, e_e, e_p}) begin
                miscompares++;
                $display("[TB] FAIL %s[%0d]: got v=%b pc=%h m=%b e=%0d p=%b, expected v=%b pc=%h m=%b e=%0d p=%b",
                         nm, k, fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken, e_v, e_pc, e_m, e_e, e_p);
            end
            if (k < 2) tick();
        end
    endtask

    task automatic test_btb();
        logic [37:0] exp [4];
`ifdef PCGEN_BTB_EN
        exp = '{{1'b0, 32'h400, 2'b00, 2'd2, 1'b0}, {1'b0, 32'h100, 2'b00, 2'd3, 1'b0},
                {1'b1, 32'h100, 2'b01, 2'd3, 1'b1}, {1'b1, 32'h400, 2'b11, 2'd3, 1'b0}};
`else
        exp = '{{1'b0, 32'h400, 2'b00, 2'd2, 1'b0}, {1'b0, 32'h100, 2'b00, 2'd3, 1'b0},
                {1'b1, 32'h100, 2'b11, 2'd3, 1'b0}, {1'b1, 32'h108, 2'b11, 2'd3, 1'b0}};
`endif
        br_taken = 1'b1; br_pc = 32'h100; br_addr = 32'h400;
        tick();
        clear_redirects();
        for (int k = 0; k < 4; k++) begin
            nm = "btb_predict"; {e_v, e_pc, e_m, e_e, e_p} = exp[k];
            vectors++;
            if ({fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken} !== {e_v, e_pc, e_m, e_e, e_p}) begin
                miscompares++;
                $display("[TB] FAIL %s[%0d]: got v=%b pc=%h m=%b e=%0d p=%b, expected v=%b pc=%h m=%b e=%0d p=%b",
                         nm, k, fetch_valid, fetch_pc, fetch_mask, fetch_epoch, pred_taken, e_v, e_pc, e_m, e_e, e_p);
            end
            if (k == 0) begin
                trap_happened = 1'b1; ctrl_pc = 32'h100;
                tick();
                clear_redirects();
            end else if (k < 3) begin
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_priority();
        test_stall();
        test_reset_async();
        test_epoch_wrap();
        test_cpu_en();
        test_addr_wrap();
        test_btb();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
